// File: rtl/trace_retire_buf_pkg.sv
// Shared trace-entry definitions for the retire-side trace buffer.
// An entry is packed as {pc, opcode}, with pc in the upper half.
package trace_retire_buf_pkg;
  localparam int          TRACE_PC_W     = 32;
  localparam int          TRACE_OP_W     = 32;
  localparam int          TRACE_ENTRY_W  = TRACE_PC_W + TRACE_OP_W;
  localparam logic [15:0] TRACE_DROP_MAX = 16'hFFFF;

  typedef struct packed {
    logic [TRACE_PC_W-1:0] pc;
    logic [TRACE_OP_W-1:0] opcode;
  } trace_entry_t;
endpackage

// File: rtl/trace_fifo.sv
// Generic pointer FIFO with push/pop/clear, level and full/empty flags.
// A push into a full FIFO is taken only when a pop frees a slot in the same cycle.
module trace_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/trace_retire_buf.sv
// Captures retired PC/opcode pairs into a small FIFO for the trace decoder,
// with retired/dropped debug counters and a sticky overflow flag.
module trace_retire_buf
  import trace_retire_buf_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enable_i,
  input  logic                       clear_i,
  input  logic                       retire_valid_i,
  input  logic [TRACE_PC_W-1:0]      retire_pc_i,
  input  logic [TRACE_OP_W-1:0]      retire_opcode_i,
  input  logic                       ready_i,
  output logic                       valid_o,
  output logic [TRACE_PC_W-1:0]      pc_o,
  output logic [TRACE_OP_W-1:0]      opcode_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  output logic [COUNT_W-1:0]         retired_count_o,
  output logic [15:0]                dropped_count_o
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  trace_entry_t wr_entry, head;
  logic         push_req, pop, full, empty, drop;

  assign push_req = retire_valid_i && enable_i;
  assign pop      = valid_o && ready_i;
  assign drop     = push_req && full && !pop;
  assign wr_entry = '{pc: retire_pc_i, opcode: retire_opcode_i};

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (TRACE_ENTRY_W),
    .PTR_W ($clog2(DEPTH)),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clear (clear_i),
    .push  (push_req),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level_o)
  );

  // Outputs come only from registered head state; zeroed when nothing is held.
  assign valid_o  = !empty;
  assign pc_o     = valid_o ? head.pc     : '0;
  assign opcode_o = valid_o ? head.opcode : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retired_count_o <= '0;
      dropped_count_o <= '0;
      overflow_o      <= 1'b0;
    end else if (clear_i) begin
      retired_count_o <= '0;
      dropped_count_o <= '0;
      overflow_o      <= 1'b0;
    end else if (push_req) begin
      // Retired counts every capture attempt, including dropped ones
      retired_count_o <= retired_count_o + COUNT_W'(1);
      if (drop) begin
        overflow_o <= 1'b1;
        if (dropped_count_o != TRACE_DROP_MAX)
          dropped_count_o <= dropped_count_o + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_trace_retire_buf.sv
// Directed bench for trace_retire_buf: expected entries are queued at issue,
// a negedge monitor pops and compares whenever the DUT hands off an entry.
module tb_trace_retire_buf;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        enable_i = 1'b0, clear_i = 1'b0, retire_valid_i = 1'b0, ready_i = 1'b0;
  logic [31:0] retire_pc_i = '0, retire_opcode_i = '0;
  logic        valid_o, overflow_o;
  logic [31:0] pc_o, opcode_o, retired_count_o;
  logic [2:0]  level_o;
  logic [15:0] dropped_count_o;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q [$];
  int          mlev = 0;
  logic [31:0] mret = '0;
  logic [15:0] mdrop = '0;
  logic        movf = 1'b0;

  trace_retire_buf #(.DEPTH(DEPTH), .COUNT_W(32)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .enable_i        (enable_i),
    .clear_i         (clear_i),
    .retire_valid_i  (retire_valid_i),
    .retire_pc_i     (retire_pc_i),
    .retire_opcode_i (retire_opcode_i),
    .ready_i         (ready_i),
    .valid_o         (valid_o),
    .pc_o            (pc_o),
    .opcode_o        (opcode_o),
    .level_o         (level_o),
    .overflow_o      (overflow_o),
    .retired_count_o (retired_count_o),
    .dropped_count_o (dropped_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handoff happens at the next posedge when valid && ready now.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected none at %0t", {pc_o, opcode_o}, $time);
        end else begin
          chk("head", {pc_o, opcode_o}, exp_q.pop_front());
        end
      end else if (!valid_o) begin
        chk("zero_mask", {pc_o, opcode_o}, 64'h0);
      end
    end
  end

  task automatic check_model();
    chk("level", 64'(level_o), 64'(mlev));
    chk("valid", 64'(valid_o), 64'(mlev > 0));
    chk("overflow", 64'(overflow_o), 64'(movf));
    chk("retired", 64'(retired_count_o), 64'(mret));
    chk("dropped", 64'(dropped_count_o), 64'(mdrop));
  endtask

  // Drive one cycle (called at posedge+1), record expectations, advance.
  task automatic cyc(bit rv, logic [31:0] pc, logic [31:0] op, bit rdy,
                     bit en = 1'b1, bit clr = 1'b0);
    bit popm, pushm;
    retire_valid_i  = rv;
    retire_pc_i     = pc;
    retire_opcode_i = op;
    ready_i         = rdy;
    enable_i        = en;
    clear_i         = clr;
    popm  = rdy && (mlev > 0);
    pushm = rv && en;
    if (clr) begin
      exp_q.delete();
      mlev = 0; mret = '0; mdrop = '0; movf = 1'b0;
    end else begin
      if (pushm) begin
        mret++;
        if (mlev < DEPTH || popm) begin
          exp_q.push_back({pc, op});
          mlev++;
        end else begin
          movf = 1'b1;
          if (mdrop != 16'hFFFF) mdrop++;
        end
      end
      if (popm) mlev--;
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_valid", 64'(valid_o), 64'h0);
    chk("rst_data", {pc_o, opcode_o}, 64'h0);
    chk("rst_level", 64'(level_o), 64'h0);
    chk("rst_cnt", {retired_count_o, dropped_count_o, 15'h0, overflow_o}, 64'h0);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Single retire: no bypass, visible one edge later
    retire_valid_i = 1'b1; retire_pc_i = 32'h8000_0000; retire_opcode_i = 32'h13;
    ready_i = 1'b1; enable_i = 1'b1;
    #1;
    chk("no_bypass", 64'(valid_o), 64'h0);
    cyc(1, 32'h8000_0000, 32'h0000_0013, 1);
    chk("t1_valid", 64'(valid_o), 64'h1);
    chk("t1_pc", 64'(pc_o), 64'h8000_0000);
    chk("t1_op", 64'(opcode_o), 64'h13);
    chk("t1_retired", 64'(retired_count_o), 64'h1);
    cyc(0, 0, 0, 1);
    chk("t1_level", 64'(level_o), 64'h0);
    cyc(0, 0, 0, 0, 1, 1);

    // Backpressure with overflow, then ordered drain
    for (int i = 0; i < 6; i++) cyc(1, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 0);
    chk("bp_level", 64'(level_o), 64'h4);
    chk("bp_ovf", 64'(overflow_o), 64'h1);
    chk("bp_dropped", 64'(dropped_count_o), 64'h2);
    chk("bp_retired", 64'(retired_count_o), 64'h6);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    chk("bp_drained", 64'(level_o), 64'h0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) cyc(1, 32'h300 + 32'(4 * i), 32'hB0 + 32'(i), 0);
    cyc(1, 32'h200, 32'h2000, 1);
    chk("pp_level", 64'(level_o), 64'h4);
    chk("pp_dropped", 64'(dropped_count_o), 64'h2);
    chk("pp_retired", 64'(retired_count_o), 64'd11);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
    chk("pp_q_empty", 64'(exp_q.size()), 64'h0);

    // Capture disabled while existing entries drain
    cyc(1, 32'h400, 32'h40, 0);
    cyc(1, 32'h404, 32'h41, 0);
    for (int i = 0; i < 10; i++) cyc(1, 32'h500 + 32'(4 * i), 32'h5, 1, 0);
    chk("en_retired", 64'(retired_count_o), 64'd13);
    chk("en_dropped", 64'(dropped_count_o), 64'h2);
    chk("en_valid", 64'(valid_o), 64'h0);
    chk("en_level", 64'(level_o), 64'h0);

    // Clear beats a concurrent push
    for (int i = 0; i < 3; i++) cyc(1, 32'h600 + 32'(4 * i), 32'h60, 0);
    chk("clr_pre_level", 64'(level_o), 64'h3);
    chk("clr_pre_ovf", 64'(overflow_o), 64'h1);
    cyc(1, 32'h6F0, 32'h6F, 0, 1, 1);
    chk("clr_level", 64'(level_o), 64'h0);
    chk("clr_valid", 64'(valid_o), 64'h0);
    chk("clr_cnt", {retired_count_o, dropped_count_o, 15'h0, overflow_o}, 64'h0);

    // Asynchronous reset between edges
    cyc(1, 32'h700, 32'h70, 0);
    cyc(1, 32'h704, 32'h71, 0);
    chk("ar_pre_level", 64'(level_o), 64'h2);
    retire_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("ar_valid", 64'(valid_o), 64'h0);
    chk("ar_data", {pc_o, opcode_o}, 64'h0);
    chk("ar_level", 64'(level_o), 64'h0);
    chk("ar_cnt", {retired_count_o, dropped_count_o, 15'h0, overflow_o}, 64'h0);
    exp_q.delete();
    mlev = 0; mret = '0; mdrop = '0; movf = 1'b0;
    #3 rst_ni = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 32'h800, 32'h80, 0);
    chk("ar_post_valid", 64'(valid_o), 64'h1);
    chk("ar_post_pc", 64'(pc_o), 64'h800);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("final_q_empty", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
